// File: rtl/prbs_os_pkg.sv
// Shared types, lane seeds and skip-mask helper for the PRBS11 ordered-set checker.
package prbs_os_pkg;

    typedef enum logic {IDLE, CHECK} state_e;

    localparam logic [10:0] PRBS11_SEED_L0 = 11'h7FF;
    localparam logic [10:0] PRBS11_SEED_L1 = 11'h770;

    localparam int DEF_OS_LEN    = 448;
    localparam int DEF_SKIP_BITS = 28;
    localparam int DEF_POLY_TAP  = 9;
    localparam int MASK_MAX      = 64;

    // Bit i set when absolute bit word_idx*data_w+i lies in the skip region.
    function automatic logic [MASK_MAX-1:0] skip_mask(
        input int word_idx,
        input int data_w,
        input int skip_bits
    );
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX; i++) begin
            m[i] = (i < data_w) && (word_idx * data_w + i < skip_bits);
        end
        return m;
    endfunction

endpackage

// File: rtl/prbs_os_checker_if.sv
// Receive-side bundle of the PRBS ordered-set checker.
// bit_err_cnt exists only when PRBS_OS_BIT_ERR_CNT_EN is defined.
interface prbs_os_checker_if #(
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 enable;
    logic                 os_start;
    logic [DATA_W-1:0]    data_in;
    logic                 err_clr;
    logic                 os_rec;
    logic                 os_err;
    logic                 rx_done;
    logic [ERR_CNT_W-1:0] err_cnt;
`ifdef PRBS_OS_BIT_ERR_CNT_EN
    logic [15:0]          bit_err_cnt;
`endif

    modport master (
        output enable, os_start, data_in, err_clr,
        input  os_rec, os_err, rx_done, err_cnt
`ifdef PRBS_OS_BIT_ERR_CNT_EN
        , input bit_err_cnt
`endif
    );

    modport slave (
        input  enable, os_start, data_in, err_clr,
        output os_rec, os_err, rx_done, err_cnt
`ifdef PRBS_OS_BIT_ERR_CNT_EN
        , output bit_err_cnt
`endif
    );

endinterface

// File: rtl/prbs_lfsr_step.sv
// Combinational DATA_W-step Fibonacci LFSR: expected word plus advanced state.
module prbs_lfsr_step #(
    parameter int LFSR_LEN = 11,
    parameter int POLY_TAP = 9,
    parameter int DATA_W   = 8
) (
    input  logic [LFSR_LEN-1:0] state_i,
    output logic [DATA_W-1:0]   exp_o,
    output logic [LFSR_LEN-1:0] state_o
);

    logic [LFSR_LEN-1:0] r;

    always_comb begin
        r     = state_i;
        exp_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            exp_o[i] = r[LFSR_LEN-1];
            r = {r[LFSR_LEN-2:0], r[LFSR_LEN-1] ^ r[POLY_TAP-1]};
        end
        state_o = r;
    end

endmodule

// File: rtl/prbs_os_checker.sv
// PRBS11 ordered-set checker: per-OS pass/fail, rx_done level, saturating error count.
// Define PRBS_OS_BIT_ERR_CNT_EN to add the saturating mismatched-bit counter.
module prbs_os_checker
    import prbs_os_pkg::*;
#(
    parameter int                  DATA_W         = 8,
    parameter int                  LFSR_LEN       = 11,
    parameter int                  POLY_TAP       = DEF_POLY_TAP,
    parameter logic [LFSR_LEN-1:0] SEED           = LFSR_LEN'(PRBS11_SEED_L0),
    parameter int                  OS_LEN         = DEF_OS_LEN,
    parameter int                  SKIP_BITS      = DEF_SKIP_BITS,
    parameter int                  GOOD_OS_TARGET = 2,
    parameter int                  ERR_CNT_W      = 8
) (
    input logic               clk,
    input logic               reset,
    prbs_os_checker_if.slave  bus
);

    localparam int WORDS  = OS_LEN / DATA_W;
    localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int GOOD_W = $clog2(GOOD_OS_TARGET + 1);
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(WORDS - 1);
    localparam logic [GOOD_W-1:0] TARGET = GOOD_W'(GOOD_OS_TARGET);

    state_e                state_q, state_d;
    logic [LFSR_LEN-1:0]   lfsr_q, lfsr_d, cur_lfsr, nxt_lfsr;
    logic [CNT_W-1:0]      cnt_q, cnt_d, idx;
    logic                  flag_q, flag_d;
    logic                  os_rec_q, os_rec_d;
    logic                  os_err_q, os_err_d;
    logic [GOOD_W-1:0]     good_q, good_d;
    logic                  rx_done_q, rx_done_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0]     exp_word;
    logic [MASK_MAX-1:0]   mask_full, miss;
    logic                  restart, checking, word_err;

    prbs_lfsr_step #(
        .LFSR_LEN (LFSR_LEN),
        .POLY_TAP (POLY_TAP),
        .DATA_W   (DATA_W)
    ) u_step (
        .state_i (cur_lfsr),
        .exp_o   (exp_word),
        .state_o (nxt_lfsr)
    );

    // os_start always re-frames: word 0 against SEED, whatever the counter says.
    assign restart   = bus.enable && bus.os_start;
    assign checking  = bus.enable && (restart || state_q == CHECK);
    assign cur_lfsr  = restart ? SEED : lfsr_q;
    assign idx       = restart ? '0 : cnt_q;
    assign mask_full = skip_mask(32'(idx), DATA_W, SKIP_BITS);
    assign miss      = MASK_MAX'(bus.data_in ^ exp_word) & ~mask_full;
    assign word_err  = |miss;

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        os_rec_d  = 1'b0;
        os_err_d  = 1'b0;
        good_d    = good_q;
        rx_done_d = rx_done_q;
        err_cnt_d = err_cnt_q;
        if (!bus.enable) begin
            state_d   = IDLE;
            lfsr_d    = SEED;
            cnt_d     = '0;
            flag_d    = 1'b0;
            good_d    = '0;
            rx_done_d = 1'b0;
        end else if (checking) begin
            state_d  = CHECK;
            flag_d   = (idx == '0) ? word_err : (flag_q | word_err);
            os_err_d = restart && state_q == CHECK && cnt_q != '0;
            if (idx == LAST) begin
                os_rec_d = !flag_d && !os_err_d;
                os_err_d = os_err_d | flag_d;
                lfsr_d   = SEED;
                cnt_d    = '0;
            end else begin
                lfsr_d   = nxt_lfsr;
                cnt_d    = idx + CNT_W'(1);
            end
        end
        if (os_err_d) begin
            good_d    = '0;
            rx_done_d = 1'b0;
        end else if (os_rec_d) begin
            good_d = (good_q == TARGET) ? good_q : good_q + GOOD_W'(1);
            if (good_d == TARGET) rx_done_d = 1'b1;
        end
        if (bus.err_clr) begin
            err_cnt_d = '0;
        end else if (os_err_d && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
            os_rec_q  <= 1'b0;
            os_err_q  <= 1'b0;
            good_q    <= '0;
            rx_done_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            os_rec_q  <= os_rec_d;
            os_err_q  <= os_err_d;
            good_q    <= good_d;
            rx_done_q <= rx_done_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.os_rec  = os_rec_q;
    assign bus.os_err  = os_err_q;
    assign bus.rx_done = rx_done_q;
    assign bus.err_cnt = err_cnt_q;

`ifdef PRBS_OS_BIT_ERR_CNT_EN
    logic [15:0] bit_err_q, bit_err_d;
    logic [16:0] bit_sum;

    always_comb begin
        bit_sum   = {1'b0, bit_err_q} + 17'($countones(miss));
        bit_err_d = bit_err_q;
        if (bus.err_clr) begin
            bit_err_d = '0;
        end else if (checking) begin
            bit_err_d = bit_sum[16] ? '1 : bit_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_err_q <= '0;
        end else begin
            bit_err_q <= bit_err_d;
        end
    end

    assign bus.bit_err_cnt = bit_err_q;
`endif

endmodule

// File: tb/tb_prbs_os_checker.sv
// Testbench for prbs_os_checker: OS table, directed corner sequences and random
// stimulus against a bit-level reference built from the x^11+x^9+1 recurrence.
module tb_prbs_os_checker;

    localparam int DW    = 8;
    localparam int WORDS = 56;
    localparam int SKIP  = 28;
    localparam int OSB   = 448;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prbs_os_checker_if #(.DATA_W(DW), .ERR_CNT_W(8)) bus ();
    prbs_os_checker dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    bit pat [OSB];
    bit m_act;
    int m_pos;
    bit m_bad;
    int m_good;
    bit m_done;
    int m_errc;
    int m_bits;

    typedef struct {
        int flip;
        bit rec;
        bit err;
        bit done;
        int errc;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pword(input int w);
        logic [7:0] d;
        for (int i = 0; i < DW; i++) d[i] = pat[w * DW + i];
        return d;
    endfunction

    task automatic model_reset();
        m_act = 0; m_pos = 0; m_bad = 0; m_good = 0;
        m_done = 0; m_errc = 0; m_bits = 0;
    endtask

    // Apply one word for one clock, predict from the spec-level model, compare.
    task automatic drive(input logic [7:0] d, input bit st, input bit en = 1'b1,
                         input bit clr = 1'b0);
        bit p_rec = 0;
        bit p_err = 0;
        int b;
        if (!en) begin
            m_act = 0; m_pos = 0; m_bad = 0; m_good = 0; m_done = 0;
        end else if (st || m_act) begin
            if (st) begin
                if (m_act && m_pos != 0) p_err = 1;
                m_pos = 0;
                m_act = 1;
            end
            if (m_pos == 0) m_bad = 0;
            for (int i = 0; i < DW; i++) begin
                b = m_pos * DW + i;
                if (b >= SKIP && d[i] != pat[b]) begin
                    m_bad = 1;
                    if (m_bits < 65535) m_bits++;
                end
            end
            if (m_pos == WORDS - 1) begin
                if (m_bad) p_err = 1;
                else if (!p_err) p_rec = 1;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        if (p_err) begin
            m_good = 0; m_done = 0;
        end else if (p_rec) begin
            m_good++;
            if (m_good >= 2) m_done = 1;
        end
        if (clr) m_errc = 0;
        else if (p_err && m_errc < 255) m_errc++;
        if (clr) m_bits = 0;
        bus.data_in = d; bus.os_start = st; bus.enable = en; bus.err_clr = clr;
        @(posedge clk); #1;
        bus.os_start = 1'b0; bus.err_clr = 1'b0;
        check("os_rec", bus.os_rec, p_rec);
        check("os_err", bus.os_err, p_err);
        check("rx_done", bus.rx_done, m_done);
        check("err_cnt", bus.err_cnt, m_errc);
`ifdef PRBS_OS_BIT_ERR_CNT_EN
        check("bit_err_cnt", bus.bit_err_cnt, m_bits);
`endif
    endtask

    task automatic send_os(input bit st, input int flip, input int nw = WORDS);
        logic [7:0] d;
        for (int w = 0; w < nw; w++) begin
            d = pword(w);
            if (flip >= 0 && flip / DW == w) d[flip % DW] = ~d[flip % DW];
            drive(d, st && w == 0);
        end
    endtask

    task automatic do_reset();
        bus.enable = 1'b1; bus.os_start = 1'b0; bus.err_clr = 1'b0; bus.data_in = '0;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("rst_os_rec", bus.os_rec, 0);
        check("rst_os_err", bus.os_err, 0);
        check("rst_rx_done", bus.rx_done, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        reset = 1'b0;
    endtask

    initial begin
        logic [10:0] seed;
        logic [7:0]  d;
        bit          st;
        bit          en;
        bit          clr;

        seed = 11'h7FF;
        for (int k = 0; k < 11; k++) pat[k] = seed[10 - k];
        for (int n = 11; n < OSB; n++) pat[n] = pat[n - 11] ^ pat[n - 9];

        tbl[0] = '{-1,  1'b1, 1'b0, 1'b0, 0};
        tbl[1] = '{10,  1'b1, 1'b0, 1'b1, 0};
        tbl[2] = '{27,  1'b1, 1'b0, 1'b1, 0};
        tbl[3] = '{28,  1'b0, 1'b1, 1'b0, 1};
        tbl[4] = '{447, 1'b0, 1'b1, 1'b0, 2};
        tbl[5] = '{0,   1'b1, 1'b0, 1'b0, 2};

        do_reset();
        check("first_word", pword(0), 8'hFF);
        for (int k = 0; k < 6; k++) begin
            send_os(1'b1, tbl[k].flip);
            check("tbl_rec", bus.os_rec, tbl[k].rec);
            check("tbl_err", bus.os_err, tbl[k].err);
            check("tbl_done", bus.rx_done, tbl[k].done);
            check("tbl_errc", bus.err_cnt, tbl[k].errc);
        end

        // Back-to-back OS from a single os_start, then an errored one.
        do_reset();
        send_os(1'b1, -1);
        check("b2b_rec1", bus.os_rec, 1);
        check("b2b_done1", bus.rx_done, 0);
        send_os(1'b0, -1);
        check("b2b_rec2", bus.os_rec, 1);
        check("b2b_done2", bus.rx_done, 1);
        send_os(1'b0, 100);
        check("b2b_err3", bus.os_err, 1);
        check("b2b_done3", bus.rx_done, 0);

        // Realign at word 20.
        do_reset();
        send_os(1'b1, -1, 20);
        drive(pword(0), 1'b1);
        check("realign_err", bus.os_err, 1);
        check("realign_errc", bus.err_cnt, 1);
        for (int w = 1; w < WORDS; w++) drive(pword(w), 1'b0);
        check("realign_rec", bus.os_rec, 1);

        // err_cnt saturation and clear against a coincident error.
        do_reset();
        for (int k = 0; k < 254; k++) send_os(k == 0, 200);
        check("sat_fe", bus.err_cnt, 8'hFE);
        for (int k = 0; k < 3; k++) begin
            send_os(1'b0, 200);
            check("sat_ff", bus.err_cnt, 8'hFF);
        end
        for (int w = 0; w < WORDS; w++) begin
            d = pword(w);
            if (w == 25) d[0] = ~d[0];
            drive(d, 1'b0, 1'b1, w == WORDS - 1);
        end
        check("clr_os_err", bus.os_err, 1);
        check("clr_err_cnt", bus.err_cnt, 0);

        // enable dropped at word 30.
        do_reset();
        send_os(1'b1, 300);
        send_os(1'b0, -1);
        send_os(1'b0, -1);
        check("en_pre_done", bus.rx_done, 1);
        send_os(1'b0, -1, 30);
        drive(pword(30), 1'b0, 1'b0);
        check("en_done", bus.rx_done, 0);
        check("en_errc", bus.err_cnt, 1);
        for (int w = 0; w < 60; w++) drive(pword(w % WORDS), 1'b0);

        // Asynchronous reset mid-OS.
        do_reset();
        send_os(1'b1, 300);
        send_os(1'b0, -1);
        send_os(1'b0, -1);
        send_os(1'b0, -1, 10);
        check("ar_pre_done", bus.rx_done, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_os_rec", bus.os_rec, 0);
        check("ar_os_err", bus.os_err, 0);
        check("ar_rx_done", bus.rx_done, 0);
        check("ar_err_cnt", bus.err_cnt, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;

        // Random framing, bit errors, enables and clears.
        for (int c = 0; c < 4000; c++) begin
            st  = (c == 0) || ($urandom_range(0, 149) == 0) ||
                  (m_act && m_pos == 0 && $urandom_range(0, 3) == 0);
            en  = ($urandom_range(0, 299) != 0);
            clr = ($urandom_range(0, 199) == 0);
            d   = pword((st || !m_act) ? 0 : m_pos);
            if ($urandom_range(0, 39) == 0) d[$urandom_range(0, 7)] ^= 1'b1;
            drive(d, st, en, clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
